// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and helpers for the UART TX round-robin arbiter.
// Revision : 1.0
// ============================================================================
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Client request bundle plus UART TX launch bundle.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_par_en;
  logic [NUM_REQ-1:0]        req_par_typ;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_p_data;
  logic                      tx_data_valid;
  logic                      tx_par_en;
  logic                      tx_par_typ;
  logic                      tx_busy;

  // System side: the clients and the UART TX instance.
  modport master (
    output req_valid, req_data, req_par_en, req_par_typ, tx_busy,
    input  req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
  );

  modport slave (
    input  req_valid, req_data, req_par_en, req_par_typ, tx_busy,
    output req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational rotate-priority encoder; search starts at ptr+1.
// Revision : 1.0
// ============================================================================
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [idx_w(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [idx_w(NUM_REQ)-1:0] gnt_idx,
  output logic                      any_gnt
);
  localparam int IW = idx_w(NUM_REQ);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int k;
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any_gnt && req[k]) begin
        any_gnt = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART TX; optional UART_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  uart_tx_arbiter_if.slave          bus,
  output logic [idx_w(NUM_REQ)-1:0] grant_id,
  output logic                      err_timeout
);
  localparam int IW = idx_w(NUM_REQ);

  localparam logic [1:0] C_ST_IDLE      = IDLE;
  localparam logic [1:0] C_ST_LAUNCH    = LAUNCH;
  localparam logic [1:0] C_ST_WAIT_BUSY = WAIT_BUSY;
  localparam logic [1:0] C_ST_WAIT_DONE = WAIT_DONE;

  logic [1:0]         r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_grant_id;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_par_en;
  logic               r_par_typ;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gnt_idx;
  logic               w_any;
  logic               w_accept;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]      r_cnt;
  logic               r_err;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any_gnt (w_any)
  );

  // rst gates the strobe so no requester sees an accept during reset.
  assign w_accept      = (r_state == C_ST_IDLE) && !bus.tx_busy && w_any && !rst;
  assign bus.req_ready = w_accept ? w_gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= C_ST_IDLE;
      r_ptr      <= IW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (w_accept) begin
            r_tx_data  <= bus.req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
            r_par_en   <= bus.req_par_en[w_gnt_idx];
            r_par_typ  <= bus.req_par_typ[w_gnt_idx];
            r_grant_id <= w_gnt_idx;
            r_state    <= C_ST_LAUNCH;
          end
        end
        C_ST_LAUNCH: begin
          r_state <= C_ST_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        C_ST_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= C_ST_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
            // TX never answered: flag it and move on without touching config.
            r_err   <= 1'b1;
            r_ptr   <= r_grant_id;
            r_state <= C_ST_IDLE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
`endif
          end
        end
        C_ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_ptr   <= r_grant_id;
            r_state <= C_ST_IDLE;
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign bus.tx_p_data     = r_tx_data;
  assign bus.tx_par_en     = r_par_en;
  assign bus.tx_par_typ    = r_par_typ;
  assign bus.tx_data_valid = (r_state == C_ST_LAUNCH);
  assign grant_id          = r_grant_id;

`ifdef UART_ARB_TIMEOUT_EN
  assign err_timeout = r_err;
`else
  assign err_timeout = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed scoreboard bench for uart_tx_arbiter with a TX busy model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [idx_w(NR)-1:0] grant_id;
  logic                 err_timeout;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [DW-1:0] data;
    logic         pe;
    logic         pt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;
  int   dly      = 0;
  int   bcnt     = 0;
  int   busy_len = 12;
  bit   model_en = 1'b1;
  bit   hold_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=no-event expected=event-within-bound", tag);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},    32'(bus.req_ready), 0);
    check({tag, "_valid"},    32'(bus.tx_data_valid), 0);
    check({tag, "_data"},     32'(bus.tx_p_data), 0);
    check({tag, "_par_en"},   32'(bus.tx_par_en), 0);
    check({tag, "_par_typ"},  32'(bus.tx_par_typ), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_err"},      32'(err_timeout), 0);
  endtask

  task automatic expect_accept(input int id, input string tag);
    int   n;
    exp_t e;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.req_ready == '0) begin
      bound_fail({tag, "_accept"});
    end else begin
      check({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << id);
      e.id   = id;
      e.data = bus.req_data[id*DW +: DW];
      e.pe   = bus.req_par_en[id];
      e.pt   = bus.req_par_typ[id];
      sb.push_back(e);
      @(negedge clk);
      check({tag, "_ready_drop"}, 32'(bus.req_ready), 0);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus.tx_busy || dly != 0 || sb.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) bound_fail({tag, "_idle"});
    repeat (2) @(negedge clk);
  endtask

  // TX model and output monitor: busy rises 2 cycles after each launch pulse.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_chk = 1'b0;
        dly      = 0;
      end
      if (bus.tx_data_valid) begin
        check("launch_spacing", {30'd0, bus.tx_busy, (dly != 0)}, 0);
        check("launch_has_expect", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          check("launch_grant_id", 32'(grant_id), 32'(cur.id));
          check("launch_data",     32'(bus.tx_p_data), 32'(cur.data));
          check("launch_par_en",   32'(bus.tx_par_en), 32'(cur.pe));
          check("launch_par_typ",  32'(bus.tx_par_typ), 32'(cur.pt));
        end
        if (model_en) dly = 2;
        hold_chk = 1'b1;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          bus.tx_busy = 1'b1;
          bcnt        = busy_len;
        end
      end else if (bus.tx_busy) begin
        if (hold_chk) begin
          check("hold_data",    32'(bus.tx_p_data), 32'(cur.data));
          check("hold_par_en",  32'(bus.tx_par_en), 32'(cur.pe));
          check("hold_par_typ", 32'(bus.tx_par_typ), 32'(cur.pt));
        end
        bcnt--;
        if (bcnt <= 0) bus.tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.req_valid   = 4'b1111;
    bus.req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_par_en  = 4'b0000;
    bus.req_par_typ = 4'b0000;

    // Reset with every requester pending: nothing may be accepted.
    repeat (2) @(negedge clk);
    #1;
    check_reset("t1_reset");
    rst = 1'b0;
    expect_accept(0, "t1_first");
    bus.req_valid = 4'b0000;
    wait_idle("t1");

    // Single requester with a long busy period.
    busy_len              = 90;
    bus.req_data[23:16]   = 8'hA5;
    bus.req_par_en[2]     = 1'b1;
    bus.req_par_typ[2]    = 1'b1;
    bus.req_valid         = 4'b0100;
    expect_accept(2, "t2_single");
    bus.req_valid = 4'b0000;
    wait_idle("t2");
    check("t2_data_after", 32'(bus.tx_p_data), 32'h0000_00A5);
    check("t2_grant_id",   32'(grant_id), 2);

    // Fresh reset so the rotation starts at requester 0.
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset("t3_reset");
    rst             = 1'b0;
    busy_len        = 6;
    bus.req_data    = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_par_en  = 4'b0101;
    bus.req_par_typ = 4'b0011;
    bus.req_valid   = 4'b1111;
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      foreach (order[i]) expect_accept(order[i], $sformatf("t3_rr%0d", i));
    end
    bus.req_valid = 4'b0000;
    wait_idle("t3");

    // Requester 1 changes its inputs while its frame is in flight.
    busy_len           = 20;
    bus.req_data[15:8] = 8'h3C;
    bus.req_par_en[1]  = 1'b1;
    bus.req_par_typ[1] = 1'b0;
    bus.req_valid      = 4'b0010;
    expect_accept(1, "t4_first");
    repeat (4) @(negedge clk);
    bus.req_data[15:8] = 8'hC3;
    bus.req_par_en[1]  = 1'b0;
    bus.req_par_typ[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_iso_data",    32'(bus.tx_p_data), 32'h0000_003C);
    check("t4_iso_par_typ", 32'(bus.tx_par_typ), 0);
    check("t4_iso_par_en",  32'(bus.tx_par_en), 1);
    expect_accept(1, "t4_second");
    bus.req_valid = 4'b0000;
    wait_idle("t4");

    // Reset while the TX is still busy with requester 3's frame.
    busy_len            = 30;
    bus.req_data[31:24] = 8'h5A;
    bus.req_par_en[3]   = 1'b1;
    bus.req_par_typ[3]  = 1'b1;
    bus.req_valid       = 4'b1000;
    expect_accept(3, "t5_pre");
    bus.req_valid = 4'b0000;
    begin
      int n = 0;
      while (!bus.tx_busy && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!bus.tx_busy) bound_fail("t5_busy_rise");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset("t5_midframe");
    @(negedge clk);
    rst                = 1'b0;
    bus.req_data[7:0]  = 8'h77;
    bus.req_par_en[0]  = 1'b1;
    bus.req_par_typ[0] = 1'b0;
    bus.req_valid      = 4'b1001;
    expect_accept(0, "t5_after");
    bus.req_valid = 4'b0000;
    wait_idle("t5");

    // TX never raises busy.
    model_en           = 1'b0;
    bus.req_data[15:8] = 8'h42;
    bus.req_valid      = 4'b0010;
    expect_accept(1, "t6_acc");
    bus.req_valid = 4'b0110;
`ifdef UART_ARB_TIMEOUT_EN
    repeat (60) @(negedge clk);
    check("t6_err_early", 32'(err_timeout), 0);
    repeat (10) @(negedge clk);
    check("t6_err_set", 32'(err_timeout), 1);
    expect_accept(2, "t6_next");
    check("t6_err_sticky", 32'(err_timeout), 1);
`else
    repeat (100) @(negedge clk);
    #1;
    check("t6_err_tied", 32'(err_timeout), 0);
    check("t6_stuck_ready", 32'(bus.req_ready), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NUM_REQ independent requesters using round-robin arbitration. Each requester supplies a data byte plus its own parity configuration. The block latches the winner's data and configuration, launches one frame into the UART TX, and holds the configuration stable until the TX reports the frame is complete. It sits between the system-side clients and the single UART TX instance in the top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, frame payload width
TIMEOUT_CYC, 64, cycles allowed for tx_busy to rise after launch (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester frame request
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
req_par_en  in  NUM_REQ  per-requester parity enable
req_par_typ  in  NUM_REQ  per-requester parity type (1=even, 0=odd)
req_ready  out  NUM_REQ  one-hot accept strobe
tx_p_data  out  DATA_W  byte to UART TX
tx_data_valid  out  1  one-cycle launch pulse to UART TX
tx_par_en  out  1  parity enable to UART TX, held for the whole frame
tx_par_typ  out  1  parity type to UART TX, held for the whole frame
tx_busy  in  1  UART TX busy flag
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
err_timeout  out  1  sticky timeout flag (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer goes to NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame abandons the frame. tx_par_en and tx_par_typ drop to 0 even if tx_busy is still high.
- States:
  - IDLE:
    - The arbiter picks the first asserted req_valid, searching from pointer+1 with wrap-around.
    - req_ready[g] is combinational, asserted only in IDLE while tx_busy=0 and some req_valid=1. At most one bit is high.
    - A transfer occurs when req_valid[g] & req_ready[g]. On transfer, the block latches req_data slice g, req_par_en[g] and req_par_typ[g] into tx_p_data, tx_par_en and tx_par_typ, and latches g into grant_id. Next state is LAUNCH.
    - If tx_busy=1, nothing is accepted.
  - LAUNCH:
    - tx_data_valid=1 for exactly this one cycle. Next state is WAIT_BUSY.
  - WAIT_BUSY:
    - The block waits for tx_busy=1, then goes to WAIT_DONE.
    - If tx_busy is already 1 on the first cycle, the transition happens next cycle.
  - WAIT_DONE:
    - The block waits for tx_busy=0. On that cycle the pointer is set to grant_id and next state is IDLE.
- Latency: tx_data_valid rises 1 cycle after the accept cycle. The minimum spacing between accepts is launch + busy period + 2 cycles.
- tx_p_data, tx_par_en and tx_par_typ change only on an accept edge. Changes to req_* inputs while a frame is in flight are ignored.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,... No requester waits more than NUM_REQ-1 frames.
- A requester that drops req_valid before it is granted loses nothing, and no state is recorded for it.
- Simultaneous req_valid and tx_busy in IDLE: there is no accept, and the pointer is unchanged.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_BUSY and increments each cycle there.
  - If it reaches TIMEOUT_CYC with tx_busy still 0, err_timeout is set (sticky until rst), the pointer advances to grant_id, and the state returns to IDLE.
  - tx_par_en and tx_par_typ keep their last values.
- Undefined:
  - There is no counter; WAIT_BUSY waits indefinitely.
  - err_timeout is tied to 0.

Decomposition:
- Package uart_arb_pkg:
  - enum typedef arb_state_t {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE}
  - localparam defaults for NUM_REQ and DATA_W
  - function idx_w(n) returning $clog2(n)
- One sub-module, rr_arbiter:
  - Purely combinational rotate-priority-encode.
  - Inputs: req vector and pointer. Outputs: one-hot grant, grant index, any_grant.
  - Instantiated once; the top holds the FSM and registers.

Test Plan:
1. Reset check: rst=1 for 2 cycles with req_valid=4'b1111 -> all outputs 0 and req_ready=0. After release, the first accept is requester 0.
2. Single requester: req_valid=4'b0100, req_data[2]=8'hA5, par_en=1, par_typ=1; TX model raises busy 2 cycles after the launch pulse for 90 cycles -> req_ready=4'b0100 for 1 cycle, then tx_data_valid for 1 cycle next cycle, tx_p_data=8'hA5, tx_par_en=1 and tx_par_typ=1 held until busy falls, grant_id=2.
3. Round-robin: all four requesters valid with bytes 8'h10..8'h13 -> launch order 0,1,2,3,0. Exactly one tx_data_valid per busy period.
4. Config isolation: requester 1 toggles req_par_typ and req_data mid-frame -> tx_par_typ and tx_p_data are unchanged until the next accept.
5. Reset mid-frame: assert rst during WAIT_DONE -> outputs 0 next cycle; after release, requester 0 is served first and no stale tx_data_valid occurs.
6. Timeout (with UART_ARB_TIMEOUT_EN): TX model never raises busy -> err_timeout=1 after 64 cycles in WAIT_BUSY and stays set, and the arbiter grants the next requester. Without the macro, the FSM stays in WAIT_BUSY and err_timeout=0.
